// File: rtl/axi_stream_demux_n_if.sv
// Addressed AXI-Stream link feeding the demux: payload, destination index and handshake.
interface axi_stream_demux_n_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [ADDR_WIDTH-1:0] taddr;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output taddr, output tvalid, input tready);
    modport slave  (input tdata, input taddr, input tvalid, output tready);
endinterface

// File: rtl/axi_stream_demux_n.sv
// Routes each addressed input beat to one of ADDR_NUM output streams through a one-entry
// input register and a one-entry holding register per output channel.
module axi_stream_demux_n #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    localparam int ADDR_NUM = 1 << ADDR_WIDTH
) (
    input  logic                  aclk_i,
    input  logic                  areset_i,
    axi_stream_demux_n_if.slave   s_axis,
    output logic [DATA_WIDTH-1:0] m_tdata_o [0:ADDR_NUM-1],
    output logic [ADDR_NUM-1:0]   m_tvalid_o,
    input  logic [ADDR_NUM-1:0]   m_tready_i,
    output logic [31:0]           beat_cnt_o,
    output logic                  busy_o
);
    logic                  inValid_q, inValid_d;
    logic [DATA_WIDTH-1:0] inData_q, inData_d;
    logic [ADDR_WIDTH-1:0] inAddr_q, inAddr_d;
    logic [ADDR_NUM-1:0]   outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outData_q [0:ADDR_NUM-1];
    logic [DATA_WIDTH-1:0] outData_d [0:ADDR_NUM-1];
    logic [31:0]           beatCnt_q, beatCnt_d;
    logic                  move;
    logic                  sReady;
    logic                  accept;

    // The input beat may leave whenever its target slot is empty or draining this cycle.
    assign move   = inValid_q && (!outValid_q[inAddr_q] || m_tready_i[inAddr_q]);
    assign sReady = !areset_i && (!inValid_q || move);
    assign accept = s_axis.tvalid && sReady;

    assign s_axis.tready = sReady;

    always_comb begin
        inValid_d = inValid_q;
        inData_d  = inData_q;
        inAddr_d  = inAddr_q;
        if (move) begin
            inValid_d = 1'b0;
        end
        if (accept) begin
            inValid_d = 1'b1;
            inData_d  = s_axis.tdata;
            inAddr_d  = s_axis.taddr;
        end
    end

    always_comb begin
        outValid_d = outValid_q & ~m_tready_i;
        outData_d  = outData_q;
        for (int k = 0; k < ADDR_NUM; k++) begin
            if (move && inAddr_q == ADDR_WIDTH'(k)) begin
                outValid_d[k] = 1'b1;
                outData_d[k]  = inData_q;
            end
        end
        beatCnt_d = beatCnt_q + 32'($countones(outValid_q & m_tready_i));
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            inValid_q  <= 1'b0;
            inData_q   <= '0;
            inAddr_q   <= '0;
            outValid_q <= '0;
            beatCnt_q  <= '0;
            for (int k = 0; k < ADDR_NUM; k++) begin
                outData_q[k] <= '0;
            end
        end else begin
            inValid_q  <= inValid_d;
            inData_q   <= inData_d;
            inAddr_q   <= inAddr_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            beatCnt_q  <= beatCnt_d;
        end
    end

    assign m_tvalid_o = outValid_q;
    assign m_tdata_o  = outData_q;
    assign beat_cnt_o = beatCnt_q;
    assign busy_o     = inValid_q || (|outValid_q);

endmodule

// File: tb/tb_axi_stream_demux_n.sv
// Directed and randomized bench for axi_stream_demux_n: per-channel expected-beat queues
// filled on input handshakes and drained by a monitor on output handshakes.
module tb_axi_stream_demux_n;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int ADDR_NUM   = 16;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic [DATA_WIDTH-1:0] mTdata [0:ADDR_NUM-1];
    logic [ADDR_NUM-1:0]   mTvalid;
    logic [ADDR_NUM-1:0]   mTready;
    logic [31:0]           beatCnt;
    logic                  busy;

    always #5 aclk = ~aclk;

    axi_stream_demux_n_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) sAxis ();

    axi_stream_demux_n #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .aclk_i     (aclk),
        .areset_i   (areset),
        .s_axis     (sAxis),
        .m_tdata_o  (mTdata),
        .m_tvalid_o (mTvalid),
        .m_tready_i (mTready),
        .beat_cnt_o (beatCnt),
        .busy_o     (busy)
    );

    int                    checkCount = 0;
    int                    failCount  = 0;
    logic [DATA_WIDTH-1:0] expQ [ADDR_NUM][$];
    logic [31:0]           modelCnt   = '0;
    bit                    monitorEn  = 1'b0;
    bit                    resetPrev  = 1'b1;
    logic [ADDR_NUM-1:0]   stallPrev  = '0;
    logic [DATA_WIDTH-1:0] dataPrev [0:ADDR_NUM-1];
    logic [31:0]           cntBase;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int occupancy();
        int n = 0;
        for (int k = 0; k < ADDR_NUM; k++) n += expQ[k].size();
        return n;
    endfunction

    // Drive one cycle of inputs just after the rising edge, then return at the falling edge.
    task automatic applyStimulus(input bit rst, input bit valid, input logic [ADDR_WIDTH-1:0] addr,
                                 input logic [DATA_WIDTH-1:0] data, input logic [ADDR_NUM-1:0] ready);
        @(posedge aclk);
        #1;
        areset       = rst;
        sAxis.tvalid = valid;
        sAxis.taddr  = addr;
        sAxis.tdata  = data;
        mTready      = ready;
        @(negedge aclk);
    endtask

    // Reference model: every accepted beat is owed, in order, to its channel; held beats = owed beats.
    always @(negedge aclk) begin
        if (monitorEn) begin
            checkOutput("beat_cnt", beatCnt, modelCnt);
            checkOutput("busy", 32'(busy), 32'(occupancy() != 0));
            checkOutput("capacity", 32'(occupancy() <= ADDR_NUM + 1), 32'd1);
            if (areset) checkOutput("tready_in_reset", 32'(sAxis.tready), 32'd0);
            else if (occupancy() == 0) checkOutput("tready_when_empty", 32'(sAxis.tready), 32'd1);
            for (int k = 0; k < ADDR_NUM; k++) begin
                if (!resetPrev && stallPrev[k]) begin
                    checkOutput($sformatf("ch%0d_hold_valid", k), 32'(mTvalid[k]), 32'd1);
                    checkOutput($sformatf("ch%0d_hold_data", k), 32'(mTdata[k]), 32'(dataPrev[k]));
                end
                if (expQ[k].size() == 0) checkOutput($sformatf("ch%0d_no_phantom", k), 32'(mTvalid[k]), 32'd0);
            end
            if (areset) begin
                for (int k = 0; k < ADDR_NUM; k++) expQ[k].delete();
                modelCnt = '0;
            end else begin
                for (int k = 0; k < ADDR_NUM; k++) begin
                    if (mTvalid[k] && mTready[k] && expQ[k].size() != 0) begin
                        checkOutput($sformatf("ch%0d_data", k), 32'(mTdata[k]), 32'(expQ[k].pop_front()));
                        modelCnt++;
                    end
                end
                if (sAxis.tvalid && sAxis.tready) expQ[sAxis.taddr].push_back(sAxis.tdata);
            end
            stallPrev = mTvalid & ~mTready;
            dataPrev  = mTdata;
            resetPrev = areset;
        end
    end

    initial begin
        areset       = 1'b1;
        sAxis.tvalid = 1'b0;
        sAxis.taddr  = '0;
        sAxis.tdata  = '0;
        mTready      = '1;
        @(posedge aclk);
        #1;
        monitorEn = 1'b1;

        // Reset held with a pending beat: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 4'h9, 16'hDEAD, '1);
            checkOutput("rst_tready", 32'(sAxis.tready), 32'd0);
            checkOutput("rst_tvalid", 32'(mTvalid), 32'd0);
            checkOutput("rst_cnt", beatCnt, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("post_rst_tready", 32'(sAxis.tready), 32'd1);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);

        // Single beat: one cycle from handshake to output valid, valid for exactly one cycle.
        applyStimulus(1'b0, 1'b1, 4'd5, 16'h1234, '1);
        checkOutput("single_tready", 32'(sAxis.tready), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("single_in_reg", 32'(mTvalid), 32'd0);
        checkOutput("single_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("single_valid", 32'(mTvalid), 32'h0020);
        checkOutput("single_data", 32'(mTdata[5]), 32'h1234);
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("single_gone", 32'(mTvalid), 32'd0);
        checkOutput("single_cnt", beatCnt, 32'd1);
        checkOutput("single_idle", 32'(busy), 32'd0);

        // Back-to-back stream across all channels.
        cntBase = beatCnt;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, i < 16, 4'(i), 16'(16'h0100 + i), '1);
            if (i < 16) checkOutput("stream_tready", 32'(sAxis.tready), 32'd1);
            if (i >= 2) begin
                checkOutput("stream_onehot", 32'(mTvalid), 32'(16'(1) << (i - 2)));
                checkOutput("stream_data", 32'(mTdata[i - 2]), 32'(16'h0100 + i - 2));
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("stream_cnt", beatCnt, cntBase + 32'd16);

        // Backpressure on channel 3.
        cntBase = beatCnt;
        applyStimulus(1'b0, 1'b1, 4'd3, 16'h00A0, ~16'h0008);
        applyStimulus(1'b0, 1'b1, 4'd3, 16'h00B0, ~16'h0008);
        checkOutput("bp_accept_b", 32'(sAxis.tready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 4'd3, 16'h00C0, ~16'h0008);
            checkOutput("bp_tready_low", 32'(sAxis.tready), 32'd0);
            checkOutput("bp_hold_a", 32'(mTdata[3]), 32'h00A0);
            checkOutput("bp_valid_a", 32'(mTvalid[3]), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 4'd3, 16'h00C0, '1);
        checkOutput("bp_release", 32'(sAxis.tready), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("bp_data_b", 32'(mTdata[3]), 32'h00B0);
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("bp_data_c", 32'(mTdata[3]), 32'h00C0);
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("bp_cnt", beatCnt, cntBase + 32'd3);
        checkOutput("bp_idle", 32'(busy), 32'd0);

        // Head-of-line blocking behind a stalled channel 2.
        applyStimulus(1'b0, 1'b1, 4'd2, 16'h0021, ~16'h0004);
        applyStimulus(1'b0, 1'b1, 4'd2, 16'h0022, ~16'h0004);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 4'd7, 16'h0077, ~16'h0004);
            checkOutput("hol_blocked", 32'(sAxis.tready), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 4'd7, 16'h0077, '1);
        checkOutput("hol_unblocked", 32'(sAxis.tready), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("hol_second_2", 32'(mTdata[2]), 32'h0022);
        checkOutput("hol_7_not_yet", 32'(mTvalid[7]), 32'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("hol_7_valid", 32'(mTvalid), 32'h0080);
        checkOutput("hol_7_data", 32'(mTdata[7]), 32'h0077);

        // Reset with three beats held.
        applyStimulus(1'b0, 1'b1, 4'd1, 16'h0111, '0);
        applyStimulus(1'b0, 1'b1, 4'd2, 16'h0222, '0);
        applyStimulus(1'b0, 1'b1, 4'd4, 16'h0444, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        checkOutput("mid_rst_held", 32'(mTvalid), 32'h0016);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '1);
            checkOutput("mid_rst_valid", 32'(mTvalid), 32'd0);
            checkOutput("mid_rst_busy", 32'(busy), 32'd0);
            checkOutput("mid_rst_cnt", beatCnt, 32'd0);
        end

        // Randomized traffic with sporadic resets, then drain.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 9) < 7, 4'($urandom),
                          16'($urandom), 16'($urandom) | 16'($urandom));
        end
        for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b0, '0, '0, '1);
        checkOutput("drain_empty", 32'(occupancy()), 32'd0);
        checkOutput("drain_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
